spi_flash_arbiter: RTL and testbench

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

---
 rtl/spi_flash_arbiter.sv | 149 ++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - two-requester SPI flash pin arbiter with guard gap and idle-hold preemption
module spi_flash_arbiter #(
    parameter int unsigned GUARD_CYCLES  = 2,
    parameter int unsigned MAX_IDLE_HOLD = 4096
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_req,
    input  logic       b_req,
    output logic       a_grant,
    output logic       b_grant,
    input  logic       a_spi_cs,
    input  logic       a_spi_sck,
    input  logic       a_spi_mosi,
    input  logic       b_spi_cs,
    input  logic       b_spi_sck,
    input  logic       b_spi_mosi,
    output logic       a_spi_miso,
    output logic       b_spi_miso,
    output logic       spi_cs,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [1:0] owner,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10,
        GUARD = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  guard_cnt_q, guard_cnt_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic        last_b_q, last_b_d;
    logic        armed_q;
    logic        preempt_q, preempt_d;
    logic        a_grant_q, b_grant_q;
    logic [1:0]  owner_q;
    logic        cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d;

    logic        own_req, own_cs, other_req, arb;
    logic [16:0] idle_inc;

    assign own_req   = (state_q == OWN_A) ? a_req    : b_req;
    assign own_cs    = (state_q == OWN_A) ? a_spi_cs : b_spi_cs;
    assign other_req = (state_q == OWN_A) ? b_req    : a_req;
    assign idle_inc  = {1'b0, idle_cnt_q} + 17'd1;

    always_comb begin
        state_d     = state_q;
        guard_cnt_d = '0;
        idle_cnt_d  = '0;
        last_b_d    = last_b_q;
        preempt_d   = 1'b0;
        arb         = 1'b0;
        case (state_q)
            IDLE: arb = armed_q;
            OWN_A, OWN_B: begin
                // An open command (cs low) always finishes before release or preemption
                if (!own_req && own_cs) begin
                    state_d = GUARD;
                end else if (own_cs && other_req) begin
                    if (idle_inc >= 17'(MAX_IDLE_HOLD)) begin
                        state_d   = GUARD;
                        preempt_d = 1'b1;
                    end else begin
                        idle_cnt_d = idle_inc[15:0];
                    end
                end
            end
            GUARD: begin
                if (guard_cnt_q == 4'(GUARD_CYCLES - 1)) arb = 1'b1;
                else guard_cnt_d = guard_cnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase

        // Round-robin tie break; last owner is updated at grant time
        if (arb) begin
            if (a_req && (!b_req || last_b_q)) begin
                state_d  = OWN_A;
                last_b_d = 1'b0;
            end else if (b_req) begin
                state_d  = OWN_B;
                last_b_d = 1'b1;
            end else begin
                state_d  = IDLE;
            end
        end

        cs_d   = 1'b1;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        if (state_q == OWN_A && state_d == OWN_A) begin
            cs_d   = a_spi_cs;
            sck_d  = a_spi_sck;
            mosi_d = a_spi_mosi;
        end else if (state_q == OWN_B && state_d == OWN_B) begin
            cs_d   = b_spi_cs;
            sck_d  = b_spi_sck;
            mosi_d = b_spi_mosi;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            guard_cnt_q <= '0;
            idle_cnt_q  <= '0;
            last_b_q    <= 1'b1;
            armed_q     <= 1'b0;
            preempt_q   <= 1'b0;
            a_grant_q   <= 1'b0;
            b_grant_q   <= 1'b0;
            owner_q     <= 2'b00;
            cs_q        <= 1'b1;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            last_b_q    <= last_b_d;
            armed_q     <= 1'b1;
            preempt_q   <= preempt_d;
            a_grant_q   <= (state_d == OWN_A);
            b_grant_q   <= (state_d == OWN_B);
            owner_q     <= (state_d == OWN_A) ? 2'b01 : (state_d == OWN_B) ? 2'b10 : 2'b00;
            cs_q        <= cs_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
        end
    end

    assign a_grant    = a_grant_q;
    assign b_grant    = b_grant_q;
    assign owner      = owner_q;
    assign preempt    = preempt_q;
    assign spi_cs     = cs_q;
    assign spi_sck    = sck_q;
    assign spi_mosi   = mosi_q;
    assign a_spi_miso = a_grant_q & spi_miso;
    assign b_spi_miso = b_grant_q & spi_miso;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - vector table plus corner sequences for spi_flash_arbiter
module tb_spi_flash_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       a_req, b_req, a_grant, b_grant;
    logic       a_spi_cs, a_spi_sck, a_spi_mosi, b_spi_cs, b_spi_sck, b_spi_mosi;
    logic       a_spi_miso, b_spi_miso, spi_cs, spi_sck, spi_mosi, spi_miso, preempt;
    logic [1:0] owner;
    logic [9:0] outs;

    spi_flash_arbiter #(.GUARD_CYCLES(2), .MAX_IDLE_HOLD(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .b_req(b_req), .a_grant(a_grant), .b_grant(b_grant),
        .a_spi_cs(a_spi_cs), .a_spi_sck(a_spi_sck), .a_spi_mosi(a_spi_mosi),
        .b_spi_cs(b_spi_cs), .b_spi_sck(b_spi_sck), .b_spi_mosi(b_spi_mosi),
        .a_spi_miso(a_spi_miso), .b_spi_miso(b_spi_miso),
        .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .owner(owner), .preempt(preempt)
    );

    // {a_grant,b_grant}_{owner}_{preempt}_{cs,sck,mosi}_{a_miso,b_miso}
    assign outs = {a_grant, b_grant, owner, preempt, spi_cs, spi_sck, spi_mosi, a_spi_miso, b_spi_miso};

    // in: {a_req,b_req}_{a cs,sck,mosi}_{b cs,sck,mosi}_{miso}
    typedef struct packed {
        logic [8:0] in;
        logic [9:0] exp;
    } vec_t;

    vec_t       tbl [23];
    logic [9:0] sb_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    localparam logic [9:0] PARKED = 10'b00_00_0_100_00;
    localparam logic [9:0] A_OWN  = 10'b10_01_0_100_00;
    localparam logic [9:0] B_OWN  = 10'b01_10_0_100_00;

    task automatic drive(input logic [8:0] v);
        {a_req, b_req, a_spi_cs, a_spi_sck, a_spi_mosi, b_spi_cs, b_spi_sck, b_spi_mosi, spi_miso} = v;
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input string name, input logic [8:0] v, input logic [9:0] exp);
        logic [9:0] e;
        drive(v);
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check(name, outs, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic       cs;
        logic [8:0] v;
        logic [9:0] e;

        tbl[0]  = '{9'b10_100_100_0, PARKED};                 // first edge after reset: no grant
        tbl[1]  = '{9'b10_100_100_0, A_OWN};
        tbl[2]  = '{9'b10_001_100_1, 10'b10_01_0_001_10};
        tbl[3]  = '{9'b11_010_100_1, 10'b10_01_0_010_10};
        tbl[4]  = '{9'b01_000_100_0, 10'b10_01_0_000_00};     // req dropped, cs low: hold
        tbl[5]  = '{9'b01_100_100_0, PARKED};
        tbl[6]  = '{9'b01_100_100_0, PARKED};
        tbl[7]  = '{9'b01_100_100_0, B_OWN};
        tbl[8]  = '{9'b01_100_011_1, 10'b01_10_0_011_01};
        tbl[9]  = '{9'b10_100_100_0, PARKED};                 // A asks as B releases
        tbl[10] = '{9'b10_100_100_0, PARKED};
        tbl[11] = '{9'b10_100_100_0, A_OWN};
        tbl[12] = '{9'b01_100_100_0, PARKED};                 // B pulse during guard
        tbl[13] = '{9'b00_100_100_0, PARKED};
        tbl[14] = '{9'b00_100_100_0, PARKED};
        tbl[15] = '{9'b00_100_100_0, PARKED};
        tbl[16] = '{9'b11_100_100_0, B_OWN};                  // tie, last owner A
        tbl[17] = '{9'b10_100_100_0, PARKED};
        tbl[18] = '{9'b11_100_100_0, PARKED};
        tbl[19] = '{9'b11_100_100_0, A_OWN};                  // tie, last owner B
        tbl[20] = '{9'b00_100_100_0, PARKED};
        tbl[21] = '{9'b00_100_100_0, PARKED};
        tbl[22] = '{9'b00_100_100_0, PARKED};

        reset_n = 1'b0;
        drive(9'b00_100_100_0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs, PARKED);
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++)
            apply($sformatf("tbl[%0d]", i), tbl[i].in, tbl[i].exp);

        // Command in flight holds the grant after req drops
        apply("hold_grant", 9'b10_100_100_0, A_OWN);
        apply("hold_cs_low", 9'b10_000_100_0, 10'b10_01_0_000_00);
        for (int i = 0; i < 10; i++)
            apply($sformatf("hold[%0d]", i), 9'b00_000_100_0, 10'b10_01_0_000_00);
        apply("hold_release", 9'b00_100_100_0, PARKED);
        apply("hold_guard", 9'b00_100_100_0, PARKED);
        apply("hold_idle", 9'b00_100_100_0, PARKED);

        // Idle-hold preemption after 8 idle cycles
        apply("pre_grant", 9'b10_100_100_0, A_OWN);
        for (int i = 1; i < 8; i++)
            apply($sformatf("pre_idle[%0d]", i), 9'b11_100_100_0, A_OWN);
        apply("pre_pulse", 9'b11_100_100_0, 10'b00_00_1_100_00);
        apply("pre_guard", 9'b11_100_100_0, PARKED);
        apply("pre_b_grant", 9'b11_100_100_0, B_OWN);
        apply("pre_rel0", 9'b00_100_100_0, PARKED);
        apply("pre_rel1", 9'b00_100_100_0, PARKED);
        apply("pre_rel2", 9'b00_100_100_0, PARKED);

        // cs pulsing low every 5 cycles keeps the owner
        apply("nopre_grant", 9'b10_100_100_0, A_OWN);
        for (int i = 0; i < 20; i++) begin
            cs = (i % 5 == 4) ? 1'b0 : 1'b1;
            v  = {2'b11, cs, 2'b00, 3'b100, 1'b0};
            e  = {2'b10, 2'b01, 1'b0, cs, 2'b00, 2'b00};
            apply($sformatf("nopre[%0d]", i), v, e);
        end
        apply("nopre_rel0", 9'b00_100_100_0, PARKED);
        apply("nopre_rel1", 9'b00_100_100_0, PARKED);
        apply("nopre_rel2", 9'b00_100_100_0, PARKED);

        // Reset mid-read, then tie after reset goes to A
        apply("rd_grant", 9'b10_100_100_0, A_OWN);
        apply("rd_miso", 9'b10_001_100_1, 10'b10_01_0_001_10);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_async", outs, PARKED);
        drive(9'b11_100_100_0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply("tie_first_edge", 9'b11_100_100_0, PARKED);
        apply("tie_a_wins", 9'b11_100_100_0, A_OWN);
        apply("tie_rel", 9'b01_100_100_0, PARKED);
        apply("tie_guard", 9'b01_100_100_0, PARKED);
        apply("tie_b_grant", 9'b01_100_100_0, B_OWN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
